// File: rtl/data_memory_ctrl.sv
// Data-memory responder for the MEM stage. Accepts a held load/store request,
// performs a byte/half/word access on an internal word-organised RAM after
// LATENCY cycles, and completes it with a one-cycle ready pulse.
//
// Handshake: memRead/memWrite act as a request that the initiator holds until
// ready. A request is sampled only in IDLE. ready is high for exactly one cycle
// (the RESP state), and the FSM always returns to IDLE afterwards. This gives at
// least one idle cycle between back-to-back accesses.
module data_memory_ctrl #(
  parameter int DM_MEM_DEPTH = 4096,
  parameter int DATA_WIDTH   = 32,
  parameter int FUNC3_WIDTH  = 3,
  parameter int LATENCY      = 2
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic [FUNC3_WIDTH-1:0] func3,
  input  logic [DATA_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  writeData,
  output logic [DATA_WIDTH-1:0]  readData,
  output logic                   ready,
  output logic                   misaligned,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DM_MEM_DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [FUNC3_WIDTH-1:0] f3_q, f3_d;
  logic [DATA_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   mis_q, mis_d;

  logic [DATA_WIDTH-1:0]  mem [DM_MEM_DEPTH];

  // Fields of the access being processed. With LATENCY==1 the FSM goes from
  // IDLE straight to RESP, so the live inputs must be used in IDLE.
  logic                   a_wr;
  logic [FUNC3_WIDTH-1:0] a_f3;
  logic [DATA_WIDTH-1:0]  a_addr;
  logic [DATA_WIDTH-1:0]  a_wdata;
  logic [AW-1:0]          a_idx;
  logic                   a_mis;
  logic                   enter_resp;
  logic                   commit_wr;
  logic [3:0]             be;
  logic [DATA_WIDTH-1:0]  wlane;
  logic [DATA_WIDTH-1:0]  word;
  logic [DATA_WIDTH-1:0]  word_sh;
  logic [7:0]             byte_v;
  logic [15:0]            half_v;
  logic [DATA_WIDTH-1:0]  load_v;

  // Select between live request (IDLE) and captured request (WAIT/RESP).
  always_comb begin
    a_wr    = wr_q;
    a_f3    = f3_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      a_wr    = memWrite;
      a_f3    = func3;
      a_addr  = addr;
      a_wdata = writeData;
    end
  end

  assign a_idx = a_addr[AW+1:2];

  // Alignment check; reserved func3 codes are always flagged.
  always_comb begin
    a_mis = 1'b1;
    case (a_f3)
      3'b000, 3'b100: a_mis = 1'b0;
      3'b001, 3'b101: a_mis = a_addr[0];
      3'b010:         a_mis = (a_addr[1:0] != 2'b00);
      default:        a_mis = 1'b1;
    endcase
  end

  // Store byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wlane = '0;
    case (a_f3)
      3'b000, 3'b100: begin
        be    = 4'b0001 << a_addr[1:0];
        wlane = {4{a_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        be    = a_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{a_wdata[15:0]}};
      end
      3'b010: begin
        be    = 4'b1111;
        wlane = a_wdata;
      end
      default: begin
        be    = 4'b0000;
        wlane = '0;
      end
    endcase
  end

  // Load extraction with sign/zero extension; misaligned loads return zero.
  always_comb begin
    word    = mem[a_idx];
    word_sh = word >> {a_addr[1:0], 3'b000};
    byte_v  = word_sh[7:0];
    half_v  = a_addr[1] ? word[31:16] : word[15:0];
    case (a_f3)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_v = {24'd0, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b101:  load_v = {16'd0, half_v};
      default: load_v = word;
    endcase
    if (a_mis) begin
      load_v = '0;
    end
  end

  // Next-state logic: request capture, latency countdown, response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (memRead || memWrite) begin
          wr_d    = memWrite;
          f3_d    = func3;
          addr_d  = addr;
          wdata_d = writeData;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP) && rstN;
  assign commit_wr  = enter_resp && a_wr && !a_mis;

  // Response registers: load data and misaligned flag update when entering RESP.
  always_comb begin
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    if (enter_resp) begin
      mis_d = a_mis;
      if (!a_wr) begin
        rdata_d = load_v;
      end
    end
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // RAM byte-lane write on the edge entering RESP; array is not reset.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[a_idx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  assign ready      = (state_q == S_RESP);
  assign misaligned = mis_q;
  assign readData   = rdata_q;
  assign dbg_state  = state_q;

endmodule
